// File: rtl/uart_apb_bridge_pkg.sv
// Shared register map, bit positions and FSM encoding for the UART APB bridge.
package uart_apb_pkg;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_RXDATA = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_RX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_TO_ERR   = 3;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;
    localparam int CTRL_SRST  = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, SRST} state_e;

endpackage

// File: rtl/uart_apb_bridge_if.sv
// APB3 bus bundle between the fabric (master) and the UART bridge (slave).
interface uart_apb_bridge_if;
    logic [31:0] PADDR;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/uart_apb_bridge_wait_timer.sv
// Wait-state counter: counts stalled access cycles and flags when TIMEOUT is reached.
module uart_apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CW'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_apb_bridge.sv
// APB3 slave exposing UART TX/RX FIFOs, STATUS and CTRL, with wait-state timeout,
// interrupt and a timed soft-reset pulse for the UART core.
module uart_apb_bridge
    import uart_apb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT     = 16,
    parameter int SRST_CYCLES = 4
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    uart_apb_bridge_if.slave  apb,
    input  logic [DATA_W-1:0] rx_fifo_dataOut,
    input  logic              rx_fifo_Empty,
    input  logic              rx_fifo_Full,
    input  logic              tx_fifo_Full,
    output logic [DATA_W-1:0] tx_fifo_dataIn,
    output logic              tx_fifo_writeEn,
    output logic              rx_fifo_readEn,
    output logic              uart_rst,
    output logic              irq
);
    localparam int SW = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [SW-1:0] srst_cnt_q, srst_cnt_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          to_err_q, to_err_d;

    logic [3:0] addr_off;
    logic acc, is_tx, is_rx, is_st, is_ct, err_acc, in_srst, fifo_rdy;
    logic rdy_norm, expired, acc_done, normal_cpl, timeout_cpl, srst_req;
    logic unused_bits;

    assign addr_off    = {apb.PADDR[3:2], 2'b00};
    assign acc         = apb.PSELx & apb.PENABLE;
    assign is_tx       = (addr_off == ADDR_TXDATA);
    assign is_rx       = (addr_off == ADDR_RXDATA);
    assign is_st       = (addr_off == ADDR_STATUS);
    assign is_ct       = (addr_off == ADDR_CTRL);
    assign err_acc     = (is_tx & ~apb.PWRITE) | (is_rx & apb.PWRITE);
    assign in_srst     = (state_q == SRST);
    // FIFO traffic is held off while the UART core is in soft reset
    assign fifo_rdy    = ~in_srst & (is_tx ? ~tx_fifo_Full : ~rx_fifo_Empty);
    assign rdy_norm    = err_acc | ~(is_tx | is_rx) | fifo_rdy;
    assign acc_done    = rdy_norm | expired;
    assign normal_cpl  = acc & rdy_norm & ~err_acc;
    assign timeout_cpl = acc & ~rdy_norm & expired;
    assign srst_req    = normal_cpl & apb.PWRITE & is_ct & apb.PWDATA[CTRL_SRST];
    assign unused_bits = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA};

    uart_apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk_i     (PCLK),
        .rst_ni    (PRESETn),
        .en_i      (acc & ~acc_done),
        .clr_i     (~apb.PSELx | (acc & acc_done)),
        .expired_o (expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            srst_cnt_q <= '0;
            ctrl_q     <= '0;
            to_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            srst_cnt_q <= srst_cnt_d;
            ctrl_q     <= ctrl_d;
            to_err_q   <= to_err_d;
        end
    end

    always_comb begin
        state_d    = IDLE;
        srst_cnt_d = srst_cnt_q;
        ctrl_d     = ctrl_q;
        to_err_d   = to_err_q;
        if (normal_cpl && apb.PWRITE && is_ct) begin
            ctrl_d[CTRL_RX_IE] = apb.PWDATA[CTRL_RX_IE];
            ctrl_d[CTRL_TX_IE] = apb.PWDATA[CTRL_TX_IE];
        end
        if (normal_cpl && apb.PWRITE && is_st && apb.PWDATA[ST_TO_ERR])
            to_err_d = 1'b0;
        // a timeout in the same cycle as a W1C keeps the error visible
        if (timeout_cpl)
            to_err_d = 1'b1;
        if (srst_req) begin
            state_d    = SRST;
            srst_cnt_d = SW'(SRST_CYCLES - 1);
        end else if (in_srst && srst_cnt_q != '0) begin
            state_d    = SRST;
            srst_cnt_d = srst_cnt_q - SW'(1);
        end else if (acc && !acc_done) begin
            state_d    = ACCESS;
        end
    end

    always_comb begin
        apb.PREADY      = 1'b0;
        apb.PSLVERR     = 1'b0;
        apb.PRDATA      = '0;
        tx_fifo_writeEn = 1'b0;
        rx_fifo_readEn  = 1'b0;
        tx_fifo_dataIn  = apb.PWDATA[DATA_W-1:0];
        uart_rst        = in_srst;
        irq             = (ctrl_q[CTRL_RX_IE] & ~rx_fifo_Empty) |
                          (ctrl_q[CTRL_TX_IE] & ~tx_fifo_Full);
        if (acc) begin
            apb.PREADY      = acc_done;
            apb.PSLVERR     = err_acc | timeout_cpl;
            tx_fifo_writeEn = normal_cpl & is_tx;
            rx_fifo_readEn  = normal_cpl & is_rx;
            if (!apb.PWRITE) begin
                case (addr_off)
                    ADDR_RXDATA: if (fifo_rdy) apb.PRDATA = 32'(rx_fifo_dataOut);
                    ADDR_STATUS: begin
                        apb.PRDATA[ST_TX_FULL]  = tx_fifo_Full;
                        apb.PRDATA[ST_RX_EMPTY] = rx_fifo_Empty;
                        apb.PRDATA[ST_RX_FULL]  = rx_fifo_Full;
                        apb.PRDATA[ST_TO_ERR]   = to_err_q;
                    end
                    ADDR_CTRL: begin
                        apb.PRDATA[CTRL_RX_IE] = ctrl_q[CTRL_RX_IE];
                        apb.PRDATA[CTRL_TX_IE] = ctrl_q[CTRL_TX_IE];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_apb_bridge.sv
// Directed bench for uart_apb_bridge: a register-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_uart_apb_bridge;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT     = 4;
    localparam int SRST_CYCLES = 4;

    logic       PCLK     = 1'b0;
    logic       PRESETn  = 1'b1;
    logic [7:0] rx_dout  = 8'h00;
    logic       rx_empty = 1'b1;
    logic       rx_full  = 1'b0;
    logic       tx_full  = 1'b0;
    logic [7:0] tx_din;
    logic       tx_we, rx_re, uart_rst, irq;

    uart_apb_bridge_if apb();

    uart_apb_bridge #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .SRST_CYCLES(SRST_CYCLES)) dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .apb             (apb),
        .rx_fifo_dataOut (rx_dout),
        .rx_fifo_Empty   (rx_empty),
        .rx_fifo_Full    (rx_full),
        .tx_fifo_Full    (tx_full),
        .tx_fifo_dataIn  (tx_din),
        .tx_fifo_writeEn (tx_we),
        .rx_fifo_readEn  (rx_re),
        .uart_rst        (uart_rst),
        .irq             (irq)
    );

    always #5 PCLK = ~PCLK;

    int vec = 0, bad = 0;
    int wr_cnt = 0, rd_cnt = 0, rst_hi = 0;

    // register-level model state
    int       m_wait  = 0;
    int       m_srst  = 0;
    logic [1:0] m_ctrl = 2'b00;
    logic     m_toerr = 1'b0;

    // expected bus/strobe response for the current inputs
    logic        e_acc, e_rdy, e_err, e_we, e_re, e_tmo, e_blk;
    logic [31:0] e_rd;
    logic [1:0]  e_idx;

    always_comb begin
        e_acc = apb.PSELx & apb.PENABLE;
        e_idx = apb.PADDR[3:2];
        e_blk = (m_srst > 0);
        e_rdy = 1'b0; e_err = 1'b0; e_we = 1'b0; e_re = 1'b0; e_tmo = 1'b0; e_rd = 32'h0;
        if (e_acc) begin
            case (e_idx)
                2'd0: if (!apb.PWRITE) begin e_rdy = 1'b1; e_err = 1'b1; end
                      else if (!tx_full && !e_blk) begin e_rdy = 1'b1; e_we = 1'b1; end
                      else if (m_wait >= TIMEOUT) begin e_rdy = 1'b1; e_err = 1'b1; e_tmo = 1'b1; end
                2'd1: if (apb.PWRITE) begin e_rdy = 1'b1; e_err = 1'b1; end
                      else if (!rx_empty && !e_blk) begin e_rdy = 1'b1; e_re = 1'b1; e_rd = {24'h0, rx_dout}; end
                      else if (m_wait >= TIMEOUT) begin e_rdy = 1'b1; e_err = 1'b1; e_tmo = 1'b1; end
                2'd2: begin
                    e_rdy = 1'b1;
                    if (!apb.PWRITE) e_rd = {28'h0, m_toerr, rx_full, rx_empty, tx_full};
                end
                default: begin
                    e_rdy = 1'b1;
                    if (!apb.PWRITE) e_rd = {30'h0, m_ctrl};
                end
            endcase
        end
    end

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_wait <= 0; m_srst <= 0; m_ctrl <= 2'b00; m_toerr <= 1'b0;
        end else begin
            if (m_srst > 0) m_srst <= m_srst - 1;
            if (e_acc && e_rdy && !e_err && apb.PWRITE) begin
                if (e_idx == 2'd3) begin
                    m_ctrl <= apb.PWDATA[1:0];
                    if (apb.PWDATA[2]) m_srst <= SRST_CYCLES;
                end
                if (e_idx == 2'd2 && apb.PWDATA[3]) m_toerr <= 1'b0;
            end
            if (e_tmo) m_toerr <= 1'b1;
            if (!apb.PSELx || (e_acc && e_rdy)) m_wait <= 0;
            else if (e_acc) m_wait <= m_wait + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge PCLK);
        chk("PREADY",   32'(apb.PREADY),  32'(e_rdy));
        chk("PSLVERR",  32'(apb.PSLVERR), 32'(e_err));
        chk("PRDATA",   apb.PRDATA,       e_rd);
        chk("writeEn",  32'(tx_we),       32'(e_we));
        chk("readEn",   32'(rx_re),       32'(e_re));
        chk("dataIn",   32'(tx_din),      32'(apb.PWDATA[7:0]));
        chk("uart_rst", 32'(uart_rst),    32'(m_srst > 0));
        chk("irq",      32'(irq),         32'((m_ctrl[0] & ~rx_empty) | (m_ctrl[1] & ~tx_full)));
        if (tx_we)    wr_cnt++;
        if (rx_re)    rd_cnt++;
        if (uart_rst) rst_hi++;
    end

    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output int nw,
                            output logic [7:0] txd);
        int  n = 0;
        bit  done = 0;
        @(posedge PCLK); #1;
        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = addr; apb.PWRITE = wr; apb.PWDATA = wd;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        rd = 32'h0; err = 1'b0; txd = 8'h0;
        while (!done && n < 40) begin
            @(negedge PCLK);
            if (apb.PREADY) begin
                done = 1; rd = apb.PRDATA; err = apb.PSLVERR; txd = tx_din;
            end else n++;
        end
        if (!done) begin
            vec++; bad++;
            $display("FAIL apb_xfer_bound: no PREADY after %0d cycles, want completion", n);
        end
        @(posedge PCLK); #1;
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
        nw = n;
    endtask

    task automatic wait_rst_low();
        int k = 0;
        while (uart_rst && k < 30) begin @(negedge PCLK); k++; end
        @(posedge PCLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        err;
    int          nw, w0, r0;
    logic [7:0]  txd;

    initial begin
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = 32'h0; apb.PWDATA = 32'h0;
        #2 PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_PREADY",   32'(apb.PREADY), 32'h0);
        chk("reset_PRDATA",   apb.PRDATA,      32'h0);
        chk("reset_uart_rst", 32'(uart_rst),   32'h0);
        chk("reset_irq",      32'(irq),        32'h0);
        PRESETn = 1'b1;

        // TXDATA write, zero wait, upper address bits ignored
        w0 = wr_cnt;
        apb_xfer(32'hABCD_0000, 1'b1, 32'h0000_12A5, rd, err, nw, txd);
        chk("tx_nwait", 32'(nw), 32'd0);
        chk("tx_err",   32'(err), 32'd0);
        chk("tx_data",  32'(txd), 32'hA5);
        chk("tx_pulses", 32'(wr_cnt - w0), 32'd1);

        // RXDATA read stalls 3 cycles on empty
        rx_dout = 8'h3C; rx_empty = 1'b1; r0 = rd_cnt;
        fork
            apb_xfer(32'h4, 1'b0, 32'h0, rd, err, nw, txd);
            begin
                while (!apb.PENABLE) @(negedge PCLK);
                repeat (3) @(posedge PCLK);
                #1 rx_empty = 1'b0;
            end
        join
        chk("rx_nwait",  32'(nw), 32'd3);
        chk("rx_data",   rd,      32'h0000_003C);
        chk("rx_pulses", 32'(rd_cnt - r0), 32'd1);
        rx_empty = 1'b1;

        // TXDATA timeout with FIFO stuck full, then sticky to_err and W1C
        tx_full = 1'b1; w0 = wr_cnt;
        apb_xfer(32'h0, 1'b1, 32'h11, rd, err, nw, txd);
        chk("tmo_err",    32'(err), 32'd1);
        chk("tmo_nwait",  32'(nw),  32'd4);
        chk("tmo_pulses", 32'(wr_cnt - w0), 32'd0);
        apb_xfer(32'h8, 1'b0, 32'h0, rd, err, nw, txd);
        chk("status_toerr", rd, 32'h0000_000B);
        apb_xfer(32'h8, 1'b1, 32'h8, rd, err, nw, txd);
        apb_xfer(32'h8, 1'b0, 32'h0, rd, err, nw, txd);
        chk("status_clr", rd, 32'h0000_0003);

        // flag clears exactly at the timeout count: normal completion wins
        w0 = wr_cnt;
        fork
            apb_xfer(32'h0, 1'b1, 32'h22, rd, err, nw, txd);
            begin
                while (!apb.PENABLE) @(negedge PCLK);
                repeat (4) @(posedge PCLK);
                #1 tx_full = 1'b0;
            end
        join
        chk("tie_err",    32'(err), 32'd0);
        chk("tie_nwait",  32'(nw),  32'd4);
        chk("tie_pulses", 32'(wr_cnt - w0), 32'd1);
        apb_xfer(32'h8, 1'b0, 32'h0, rd, err, nw, txd);
        chk("tie_status", rd, 32'h0000_0002);

        // illegal-direction accesses
        rx_empty = 1'b0; r0 = rd_cnt;
        apb_xfer(32'h0, 1'b0, 32'h0, rd, err, nw, txd);
        chk("rd_tx_err",  32'(err), 32'd1);
        chk("rd_tx_data", rd, 32'h0);
        apb_xfer(32'h4, 1'b1, 32'h55, rd, err, nw, txd);
        chk("wr_rx_err",    32'(err), 32'd1);
        chk("wr_rx_pulses", 32'(rd_cnt - r0), 32'd0);
        rx_empty = 1'b1;

        // soft reset pulse, then restart during the pulse
        rst_hi = 0;
        apb_xfer(32'hC, 1'b1, 32'h4, rd, err, nw, txd);
        wait_rst_low();
        chk("srst_len", 32'(rst_hi), 32'd4);
        apb_xfer(32'hC, 1'b0, 32'h0, rd, err, nw, txd);
        chk("ctrl_srst_reads0", rd, 32'h0);
        rst_hi = 0;
        apb_xfer(32'hC, 1'b1, 32'h4, rd, err, nw, txd);
        apb_xfer(32'hC, 1'b1, 32'h4, rd, err, nw, txd);
        wait_rst_low();
        chk("srst_ext_len", 32'(rst_hi), 32'd7);

        // RX access held off until the pulse ends
        rx_empty = 1'b0; rx_dout = 8'h5A;
        apb_xfer(32'hC, 1'b1, 32'h4, rd, err, nw, txd);
        apb_xfer(32'h4, 1'b0, 32'h0, rd, err, nw, txd);
        chk("srst_rx_nwait", 32'(nw), 32'd2);
        chk("srst_rx_data",  rd, 32'h0000_005A);
        wait_rst_low();
        rx_empty = 1'b1;

        // interrupt enables
        apb_xfer(32'hC, 1'b1, 32'h1, rd, err, nw, txd);
        tx_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge PCLK); #1 rx_empty = ~rx_empty;
        end
        #1 chk("irq_rx_empty", 32'(irq), 32'd0);
        @(posedge PCLK); #1 rx_empty = 1'b0;
        #1 chk("irq_rx_data", 32'(irq), 32'd1);
        rx_empty = 1'b1;
        apb_xfer(32'hC, 1'b1, 32'h3, rd, err, nw, txd);
        apb_xfer(32'hC, 1'b0, 32'h0, rd, err, nw, txd);
        chk("ctrl_read", rd, 32'h3);
        tx_full = 1'b0;
        #1 chk("irq_tx", 32'(irq), 32'd1);

        // reset in the middle of a stalled access and a soft-reset pulse
        rx_empty = 1'b0;
        apb_xfer(32'hC, 1'b1, 32'h5, rd, err, nw, txd);
        tx_full = 1'b1;
        @(posedge PCLK); #1;
        apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 32'h0; apb.PWRITE = 1'b1; apb.PWDATA = 32'h77;
        @(posedge PCLK); #1 apb.PENABLE = 1'b1;
        @(negedge PCLK); #1;
        chk("pre_rst_uart_rst", 32'(uart_rst), 32'd1);
        chk("pre_rst_irq",      32'(irq),      32'd1);
        PRESETn = 1'b0;
        #1;
        chk("rst_PREADY",   32'(apb.PREADY), 32'd0);
        chk("rst_uart_rst", 32'(uart_rst),   32'd0);
        chk("rst_irq",      32'(irq),        32'd0);
        apb.PSELx = 1'b0; apb.PENABLE = 1'b0; tx_full = 1'b0; rx_empty = 1'b1;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        apb_xfer(32'hC, 1'b0, 32'h0, rd, err, nw, txd);
        chk("post_rst_ctrl", rd, 32'h0);
        apb_xfer(32'h8, 1'b0, 32'h0, rd, err, nw, txd);
        chk("post_rst_status", rd, 32'h0000_0002);

        repeat (2) @(posedge PCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/uart_apb_bridge.md
# uart_apb_bridge

APB3 slave that maps the UART's TX and RX byte FIFOs, a status register and a control register onto the peripheral bus. It sits between the system APB fabric and the UART core's FIFOs. It inserts wait states while a FIFO cannot accept or supply data, and ends a stalled access with PSLVERR after a programmable timeout. It also provides an interrupt output and a timed soft-reset pulse for the UART core.

## Interface
- DATA_W, 8: UART character width; must be ≤ 32.
- TIMEOUT, 16: maximum wait-state cycles before an error completion; must be ≥ 1.
- SRST_CYCLES, 4: length of the uart_rst pulse in PCLK cycles; must be ≥ 1.

Ports (clock and reset first):
- PCLK  in  1  bus clock; the only clock.
- PRESETn  in  1  asynchronous, active-low reset.
- PADDR  in  32  byte address; only bits [3:2] are decoded, bits [31:4] are ignored.
- PSELx, PENABLE, PWRITE  in  1 each  APB3 control signals.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  access-phase completion.
- PSLVERR  out  1  error response, qualified by PREADY.
- rx_fifo_dataOut  in  DATA_W  head of the RX FIFO; show-ahead, valid while not empty.
- rx_fifo_Empty, rx_fifo_Full, tx_fifo_Full  in  1 each  FIFO flags.
- tx_fifo_dataIn  out  DATA_W  write data for the TX FIFO.
- tx_fifo_writeEn, rx_fifo_readEn  out  1 each  single-cycle push and pop strobes.
- uart_rst  out  1  active-high soft reset to the UART core.
- irq  out  1  level interrupt.

## Operation
Register map (offset from PADDR[3:2]):
- 0x0 TXDATA, write-only. Pushes PWDATA[DATA_W-1:0]. A read of TXDATA returns 0 with PSLVERR=1.
- 0x4 RXDATA, read-only. Pops one character, zero-extended to 32 bits. A write to RXDATA is an error.
- 0x8 STATUS, read; write-1-to-clear on bit 3.
  - bit0 tx_full, bit1 rx_empty, bit2 rx_full: live flag values.
  - bit3 to_err: sticky; set by any timeout completion.
- 0xC CTRL, read/write.
  - bit0 rx_ie, bit1 tx_ie: interrupt enables.
  - bit2 srst: write 1 to start a soft-reset pulse; always reads 0.

FSM states:
- IDLE: no transfer.
- ACCESS: PSELx & PENABLE, completing or waiting.
- SRST: soft-reset pulse in progress.

Access rules:
- A TXDATA write is "ready" when !tx_fifo_Full. An RXDATA read is "ready" when !rx_fifo_Empty.
- STATUS, CTRL and all error accesses are always ready.
- While not ready, the wait counter increments each ACCESS cycle.
- When wait count == TIMEOUT, the access completes with PREADY=1 and PSLVERR=1. No FIFO strobe is issued, and to_err is set.
- On a normal completion, exactly one strobe pulses, in the same cycle as PREADY.
- tx_fifo_dataIn = PWDATA[DATA_W-1:0], combinational.
- irq = (rx_ie & !rx_fifo_Empty) | (tx_ie & !tx_fifo_Full).

Soft reset:
- uart_rst is held high for exactly SRST_CYCLES cycles.
- A srst write issued while a pulse is in progress restarts the count.
- APB access remains serviced during SRST, but TXDATA and RXDATA accesses wait until SRST ends. Their wait counter still runs.

## Timing
- Reset values: PREADY, PSLVERR, both strobes, uart_rst and irq = 0; PRDATA = 0; CTRL = 0; to_err = 0; wait counter = 0; FSM = IDLE.
- PREADY, PSLVERR, PRDATA and the strobes are combinational from the ACCESS condition and the registered state. A ready access therefore completes with zero wait states: setup cycle plus one access cycle.
- A strobe is asserted only when PSELx & PENABLE & PREADY & !PSLVERR.
- The wait counter clears on completion and whenever PSELx drops. Dropping PSELx mid-wait aborts the access without any strobe.
- Flag deassertion in the same cycle as a timeout (wait count == TIMEOUT): the normal completion wins.
- If a to_err set and a W1C clear occur in the same cycle, set wins.
- PRESETn assertion mid-access or mid-SRST clears everything immediately. uart_rst falls asynchronously.
- Outside ACCESS, PRDATA = 0 and PREADY = 0.

## Structure
- Package uart_apb_pkg holds:
  - register offsets ADDR_TXDATA, ADDR_RXDATA, ADDR_STATUS, ADDR_CTRL;
  - STATUS and CTRL bit-index constants;
  - the FSM state typedef (IDLE, ACCESS, SRST).
- One sub-module: uart_apb_wait_timer.
  - Parameterised by TIMEOUT.
  - Inputs: count-enable, clear.
  - Output: expired.
- Decode, registers and FSM stay in the top level.

## Test plan
- TXDATA write 0xA5, tx_fifo_Full=0: PREADY in the first access cycle, tx_fifo_writeEn pulses once with tx_fifo_dataIn=0xA5, PSLVERR=0.
- RXDATA read with rx_fifo_Empty=1 for 3 cycles, then 0 and dataOut=0x3C (TIMEOUT=16): 3 wait states, PRDATA=0x0000003C, one rx_fifo_readEn pulse.
- TXDATA write with tx_fifo_Full stuck at 1, TIMEOUT=4: PREADY=PSLVERR=1 after 4 waits, no writeEn, STATUS read returns bit3=1. Writing 0x8 to STATUS clears it.
- CTRL write 0x4 with SRST_CYCLES=4: uart_rst high for exactly 4 cycles. A second write on cycle 2 extends the pulse to end 4 cycles later.
- CTRL=0x1 with rx_fifo_Empty toggling: irq follows !rx_fifo_Empty. PRESETn low mid-wait: PREADY=0 and CTRL=0 immediately.
